puzzle_move_ctrl: RTL and testbench

PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

---
 rtl/puzzle_pkg.sv | 81 ++++++++
 rtl/puzzle_tile_swap.sv | 29 ++
 rtl/puzzle_move_ctrl.sv | 173 +++++++++++++++++
 tb/tb_puzzle_move_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared definitions for the 8-puzzle move controller.
// Contents: FSM state enum, register-file addresses, direction and error
// codes, board geometry, and small helpers for tile access and move rules.
package puzzle_pkg;

  localparam int BOARD_W   = 36;
  localparam int TILE_W    = 4;
  localparam int NUM_TILES = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_SCAN,
    ST_CHECK,
    ST_WR_BOARD,
    ST_WR_DEPTH,
    ST_WR_DIR,
    ST_DONE
  } state_t;

  // Register-file map
  localparam logic [4:0] ADDR_BOARD = 5'd0;
  localparam logic [4:0] ADDR_IDEAL = 5'd1;
  localparam logic [4:0] ADDR_DEPTH = 5'd3;
  localparam logic [4:0] ADDR_HIST  = 5'd4;

  // Direction the blank moves
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Result codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_DEPTH    = 2'b10;
  localparam logic [1:0] ERR_NO_BLANK = 2'b11;

  localparam logic [3:0] DEPTH_MAX = 4'd15;

  // Tile idx lives at bits [35-4*idx : 32-4*idx]; out-of-range idx reads 0.
  function automatic logic [TILE_W-1:0] get_tile(input logic [BOARD_W-1:0] board,
                                                 input logic [3:0] idx);
    logic [TILE_W-1:0] tile;
    tile = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (idx == 4'(i)) tile = board[BOARD_W-1-TILE_W*i -: TILE_W];
    end
    return tile;
  endfunction

  // True when the blank at k cannot move in direction d (would leave the 3x3 grid).
  function automatic logic move_illegal(input logic [3:0] k, input logic [1:0] d);
    logic col0;
    logic col2;
    logic bad;
    col0 = (k == 4'd0) || (k == 4'd3) || (k == 4'd6);
    col2 = (k == 4'd2) || (k == 4'd5) || (k == 4'd8);
    case (d)
      DIR_UP:   bad = (k < 4'd3);
      DIR_DOWN: bad = (k > 4'd5);
      DIR_LEFT: bad = col0;
      default:  bad = col2;
    endcase
    return bad;
  endfunction

  // Index the blank moves into; only meaningful when the move is legal.
  function automatic logic [3:0] move_target(input logic [3:0] k, input logic [1:0] d);
    logic [3:0] t;
    case (d)
      DIR_UP:   t = k - 4'd3;
      DIR_DOWN: t = k + 4'd3;
      DIR_LEFT: t = k - 4'd1;
      default:  t = k + 4'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/puzzle_tile_swap.sv
// Combinational tile swap: returns board with tiles idx_a and idx_b exchanged.
// Ports: board (in, 36), idx_a/idx_b (in, 4), swapped (out, 36).
// Indices outside 0..8 leave every tile in place except that a valid index
// paired with an invalid one receives a zero tile (never used by the caller).
module puzzle_tile_swap
  import puzzle_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [3:0]         idx_a,
  input  logic [3:0]         idx_b,
  output logic [BOARD_W-1:0] swapped
);

  logic [TILE_W-1:0] tile_a;
  logic [TILE_W-1:0] tile_b;

  assign tile_a = get_tile(board, idx_a);
  assign tile_b = get_tile(board, idx_b);

  generate
    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tile
      localparam int HI = BOARD_W - 1 - TILE_W * gi;
      assign swapped[HI -: TILE_W] = (idx_a == 4'(gi)) ? tile_b :
                                     (idx_b == 4'(gi)) ? tile_a :
                                     board[HI -: TILE_W];
    end
  endgenerate

endmodule

// File: rtl/puzzle_move_ctrl.sv
// 8-puzzle move controller. Reads board/ideal/depth/history from an external
// register file, finds the blank, validates and applies one move, then writes
// back the new board, incremented depth and shifted direction history.
// Ports: clk, rst_n (async active-low); start/dir request a move;
// rf_src0/rf_src1 + rf_data0/rf_data1 are two combinational read ports;
// rf_dst/rf_wdata/rf_we form the write port; busy, done (1-cycle pulse),
// solved, err_code and blank_pos report status.
module puzzle_move_ctrl #(
  parameter int BOARD_W = 36,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         dir,
  output logic [ADDR_W-1:0]  rf_src0,
  output logic [ADDR_W-1:0]  rf_src1,
  input  logic [BOARD_W-1:0] rf_data0,
  input  logic [BOARD_W-1:0] rf_data1,
  output logic [ADDR_W-1:0]  rf_dst,
  output logic [BOARD_W-1:0] rf_wdata,
  output logic               rf_we,
  output logic               busy,
  output logic               done,
  output logic               solved,
  output logic [1:0]         err_code,
  output logic [3:0]         blank_pos
);
  import puzzle_pkg::*;

  state_t             state_reg;
  state_t             state_next;
  logic [1:0]         dir_reg;
  logic [BOARD_W-1:0] board_reg;
  logic [BOARD_W-1:0] ideal_reg;
  logic [BOARD_W-1:0] new_board_reg;
  logic [3:0]         depth_reg;
  logic [29:0]        hist_reg;
  logic [3:0]         scan_idx_reg;
  logic [3:0]         blank_pos_reg;
  logic               solved_reg;
  logic [1:0]         err_reg;

  logic [TILE_W-1:0]  scan_tile;
  logic               illegal;
  logic [3:0]         target;
  logic [BOARD_W-1:0] swapped_board;

  assign scan_tile = get_tile(board_reg, scan_idx_reg);
  assign illegal   = move_illegal(blank_pos_reg, dir_reg);
  assign target    = move_target(blank_pos_reg, dir_reg);

  puzzle_tile_swap u_swap (
    .board   (board_reg),
    .idx_a   (blank_pos_reg),
    .idx_b   (target),
    .swapped (swapped_board)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rf_src0    = '0;
    rf_src1    = '0;
    rf_dst     = '0;
    rf_wdata   = '0;
    rf_we      = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RD_A;
      ST_RD_A: begin
        rf_src0    = ADDR_W'(ADDR_BOARD);
        rf_src1    = ADDR_W'(ADDR_IDEAL);
        state_next = ST_RD_B;
      end
      ST_RD_B: begin
        rf_src0    = ADDR_W'(ADDR_DEPTH);
        rf_src1    = ADDR_W'(ADDR_HIST);
        state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_tile == '0)               state_next = ST_CHECK;
        else if (scan_idx_reg == 4'd8)     state_next = ST_DONE;
      end
      ST_CHECK: begin
        if (illegal || (depth_reg == DEPTH_MAX)) state_next = ST_DONE;
        else                                     state_next = ST_WR_BOARD;
      end
      ST_WR_BOARD: begin
        rf_we      = 1'b1;
        rf_dst     = ADDR_W'(ADDR_BOARD);
        rf_wdata   = new_board_reg;
        state_next = ST_WR_DEPTH;
      end
      ST_WR_DEPTH: begin
        rf_we      = 1'b1;
        rf_dst     = ADDR_W'(ADDR_DEPTH);
        rf_wdata   = BOARD_W'(depth_reg + 4'd1);
        state_next = ST_WR_DIR;
      end
      ST_WR_DIR: begin
        rf_we      = 1'b1;
        rf_dst     = ADDR_W'(ADDR_HIST);
        // Oldest direction falls off the top of the 15-entry history.
        rf_wdata   = BOARD_W'({hist_reg[27:0], dir_reg});
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_reg       <= '0;
      board_reg     <= '0;
      ideal_reg     <= '0;
      new_board_reg <= '0;
      depth_reg     <= '0;
      hist_reg      <= '0;
      scan_idx_reg  <= '0;
      blank_pos_reg <= '0;
      solved_reg    <= 1'b0;
      err_reg       <= ERR_OK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dir_reg    <= dir;
            solved_reg <= 1'b0;
            err_reg    <= ERR_OK;
          end
        end
        ST_RD_A: begin
          board_reg <= rf_data0;
          ideal_reg <= rf_data1;
        end
        ST_RD_B: begin
          depth_reg    <= rf_data0[3:0];
          hist_reg     <= rf_data1[29:0];
          scan_idx_reg <= '0;
        end
        ST_SCAN: begin
          if (scan_tile == '0)           blank_pos_reg <= scan_idx_reg;
          else if (scan_idx_reg == 4'd8) err_reg       <= ERR_NO_BLANK;
          scan_idx_reg <= scan_idx_reg + 4'd1;
        end
        ST_CHECK: begin
          // Illegal move outranks the depth limit.
          if (illegal) begin
            err_reg <= ERR_ILLEGAL;
          end else if (depth_reg == DEPTH_MAX) begin
            err_reg <= ERR_DEPTH;
          end else begin
            new_board_reg <= swapped_board;
            solved_reg    <= (swapped_board == ideal_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign solved    = solved_reg;
  assign err_code  = err_reg;
  assign blank_pos = blank_pos_reg;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
module tb_puzzle_move_ctrl;
  localparam int BW = 36;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    dir = 2'b00;
  logic [AW-1:0] rf_src0, rf_src1, rf_dst;
  logic [BW-1:0] rf_data0, rf_data1, rf_wdata;
  logic          rf_we, busy, done, solved;
  logic [1:0]    err_code;
  logic [3:0]    blank_pos;

  logic [BW-1:0] rf [0:31];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [BW-1:0] load_data = '0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int failures = 0;

  puzzle_move_ctrl #(.BOARD_W(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .rf_src0(rf_src0), .rf_src1(rf_src1),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .rf_dst(rf_dst), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .busy(busy), .done(done), .solved(solved),
    .err_code(err_code), .blank_pos(blank_pos)
  );

  always #5 clk = ~clk;

  assign rf_data0 = rf[rf_src0];
  assign rf_data1 = rf[rf_src1];

  always @(posedge clk) begin
    if (rf_we) begin
      rf[rf_dst] <= rf_wdata;
      wr_cnt     <= wr_cnt + 1;
    end else if (load_en) begin
      rf[load_addr] <= load_data;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [35:0] d);
    @(negedge clk);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // lat = number of the edge (counted from the start-sampling edge) at which
  // done is sampled high; -1 when aborted by reset, 0 on timeout.
  task automatic do_move(input string name, input logic [1:0] d, input bit poke,
                         input bit abort, output int lat, output int nwr);
    int w0;
    w0  = wr_cnt;
    lat = 0;
    @(negedge clk);
    dir   = d;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        chk({name, " rd_a src0"}, 64'(rf_src0), 64'd0);
        chk({name, " rd_a src1"}, 64'(rf_src1), 64'd1);
      end
      if (n == 2) begin
        chk({name, " busy"}, 64'(busy), 64'd1);
        chk({name, " rd_b src0"}, 64'(rf_src0), 64'd3);
        chk({name, " rd_b src1"}, 64'(rf_src1), 64'd4);
      end
      if (poke && n == 4) begin start = 1'b1; dir = 2'b11; end
      if (poke && n == 5) start = 1'b0;
      if (abort && rf_we && rf_dst == 5'd3) begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst busy",   64'(busy), 64'd0);
        chk("rst rf_we",  64'(rf_we), 64'd0);
        chk("rst done",   64'(done), 64'd0);
        chk("rst solved", 64'(solved), 64'd0);
        chk("rst err",    64'(err_code), 64'd0);
        chk("rst blank",  64'(blank_pos), 64'd0);
        chk("rst dst",    64'(rf_dst), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        break;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    if (poke && lat > 0) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      chk({name, " start in done ignored"}, 64'(busy), 64'd0);
      @(negedge clk);
      start = 1'b0;
    end
    nwr = wr_cnt - w0;
    $display("move %s dir=%0d lat=%0d writes=%0d solved=%0d err=%0d blank=%0d",
             name, d, lat, nwr, solved, err_code, blank_pos);
  endtask

  initial begin
    int lat, nwr, d0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset busy",   64'(busy), 64'd0);
    chk("reset done",   64'(done), 64'd0);
    chk("reset rf_we",  64'(rf_we), 64'd0);
    chk("reset solved", 64'(solved), 64'd0);
    chk("reset err",    64'(err_code), 64'd0);
    chk("reset blank",  64'(blank_pos), 64'd0);
    chk("reset src0",   64'(rf_src0), 64'd0);
    chk("reset src1",   64'(rf_src1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Winning move: blank at 5 moves down.
    load(5'd0, 36'h123450786);
    load(5'd1, 36'h123456780);
    load(5'd3, 36'h0);
    load(5'd4, 36'h0);
    do_move("win", 2'b01, 1'b0, 1'b0, lat, nwr);
    chk("win latency", 64'(lat), 64'd13);
    chk("win blank",   64'(blank_pos), 64'd5);
    chk("win solved",  64'(solved), 64'd1);
    chk("win err",     64'(err_code), 64'd0);
    chk("win writes",  64'(nwr), 64'd3);
    chk("win board",   64'(rf[0]), 64'h123456780);
    chk("win depth",   64'(rf[3]), 64'd1);
    chk("win hist",    64'(rf[4]), 64'd1);
    repeat (3) @(negedge clk);
    chk("win solved held", 64'(solved), 64'd1);

    // Illegal: blank at 5 moving right.
    load(5'd0, 36'h123450786);
    load(5'd3, 36'h0);
    load(5'd4, 36'h0);
    do_move("illegal", 2'b11, 1'b0, 1'b0, lat, nwr);
    chk("illegal latency", 64'(lat), 64'd10);
    chk("illegal err",     64'(err_code), 64'd1);
    chk("illegal solved",  64'(solved), 64'd0);
    chk("illegal writes",  64'(nwr), 64'd0);

    // Depth limit with a legal direction.
    load(5'd3, 36'd15);
    do_move("depth", 2'b01, 1'b0, 1'b0, lat, nwr);
    chk("depth latency", 64'(lat), 64'd10);
    chk("depth err",     64'(err_code), 64'd2);
    chk("depth blank",   64'(blank_pos), 64'd5);
    chk("depth writes",  64'(nwr), 64'd0);

    // No blank: nine SCAN cycles then DONE.
    load(5'd0, 36'h123456789);
    load(5'd3, 36'h0);
    do_move("noblank", 2'b01, 1'b0, 1'b0, lat, nwr);
    chk("noblank latency", 64'(lat), 64'd12);
    chk("noblank err",     64'(err_code), 64'd3);
    chk("noblank writes",  64'(nwr), 64'd0);

    // start pulses while busy and during DONE are ignored.
    load(5'd0, 36'h123450786);
    load(5'd3, 36'h0);
    load(5'd4, 36'h0);
    d0 = done_cnt;
    do_move("busy", 2'b01, 1'b1, 1'b0, lat, nwr);
    chk("busy latency", 64'(lat), 64'd13);
    repeat (5) @(negedge clk);
    chk("busy one done", 64'(done_cnt - d0), 64'd1);
    chk("busy idle",     64'(busy), 64'd0);
    chk("busy hist",     64'(rf[4]), 64'd1);

    // Reset during WR_DEPTH: board write stays, depth/history untouched.
    load(5'd0, 36'h123450786);
    load(5'd3, 36'h0);
    load(5'd4, 36'h0);
    do_move("abort", 2'b01, 1'b0, 1'b1, lat, nwr);
    chk("abort reached", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("abort writes",  64'(nwr), 64'd1);
    chk("abort board",   64'(rf[0]), 64'h123456780);
    chk("abort depth",   64'(rf[3]), 64'd0);
    chk("abort hist",    64'(rf[4]), 64'd0);

    // Next move behaves normally: blank at 8 moves left.
    do_move("after", 2'b10, 1'b0, 1'b0, lat, nwr);
    chk("after latency", 64'(lat), 64'd16);
    chk("after blank",   64'(blank_pos), 64'd8);
    chk("after solved",  64'(solved), 64'd0);
    chk("after err",     64'(err_code), 64'd0);
    chk("after board",   64'(rf[0]), 64'h123456708);
    chk("after depth",   64'(rf[3]), 64'd1);
    chk("after hist",    64'(rf[4]), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
